// File: rtl/bist_pkg.sv
// Shared types and constants for the Wishbone BIST master.
// Contents: FSM state encoding, byte-select constant, error-counter width,
// and a helper that sizes the row index (minimum 1 bit).
package bist_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ERR_CNT_W = 16;
    localparam logic [3:0]  SEL_ALL   = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_WR_GAP  = 3'd3,
        ST_RD_REQ  = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_RD_GAP  = 3'd6,
        ST_DONE    = 3'd7
    } bist_state_e;

    // Row-index width; a single-row configuration still needs one bit.
    function automatic int unsigned bist_addr_w(input int unsigned rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/bist_pattern_gen.sv
// Test-pattern generator: data(row) = PATTERN ^ zero-extended row index.
// Shared by the write path and the read-compare path so both always agree.
// Ports:
//   row_i     in   ROW_W  row index
//   data_c_o  out  32     combinational pattern word for that row
module bist_pattern_gen
    import bist_pkg::*;
#(
    parameter logic [DATA_W-1:0] PATTERN = 32'hA5A5_A5A5,
    parameter int unsigned       ROW_W   = 9
) (
    input  logic [ROW_W-1:0]  row_i,
    output logic [DATA_W-1:0] data_c_o
);

    assign data_c_o = PATTERN ^ DATA_W'(row_i);

endmodule

// File: rtl/wishbone_bist_master.sv
// Wishbone initiator that writes a deterministic pattern to every RAM row,
// reads every row back and counts mismatches. One transfer per bus cycle,
// with cyc/stb dropped between transfers so the slave bridge can re-arm.
// Optional build macro: BIST_ERR_CAPTURE_EN adds first-failure capture ports.
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   start_i                     1-cycle start pulse, honoured only when idle
//   wbm_cyc/stb/we/sel/adr/dat_o  Wishbone master request (registered)
//   wbm_dat_i, wbm_ack_i        Wishbone slave response
//   busy_o, done_o, pass_o      run status (done sticky until next start)
//   timeout_o                   sticky; a strobe waited too long for ack
//   err_count_o                 saturating count of mismatching rows
//   first_fail_row_o/data_o     (BIST_ERR_CAPTURE_EN only) first mismatch
module wishbone_bist_master
    import bist_pkg::*;
#(
    parameter int unsigned       NO_OF_ROWS     = 256,
    parameter logic [DATA_W-1:0] BASE_ADDR      = 32'h3000_0000,
    parameter logic [DATA_W-1:0] PATTERN        = 32'hA5A5_A5A5,
    parameter int unsigned       TIMEOUT_CYCLES = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start_i,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [3:0]           wbm_sel_o,
    output logic [DATA_W-1:0]    wbm_adr_o,
    output logic [DATA_W-1:0]    wbm_dat_o,
    input  logic [DATA_W-1:0]    wbm_dat_i,
    input  logic                 wbm_ack_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 timeout_o,
    output logic [ERR_CNT_W-1:0] err_count_o
`ifdef BIST_ERR_CAPTURE_EN
    ,
    output logic [bist_addr_w(NO_OF_ROWS)-1:0] first_fail_row_o,
    output logic [DATA_W-1:0]                  first_fail_data_o
`endif
);

    localparam int unsigned ADDR_W = bist_addr_w(NO_OF_ROWS);
    localparam int unsigned ROW_W  = ADDR_W + 1;
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NO_OF_ROWS - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    bist_state_e state_q, state_d;

    logic                 cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [3:0]           sel_q, sel_d;
    logic [DATA_W-1:0]    adr_q, adr_d, dat_q, dat_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
    logic                 busy_q, busy_d, done_q, done_d, pass_q, pass_d, tmo_q, tmo_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
`ifdef BIST_ERR_CAPTURE_EN
    logic [ADDR_W-1:0]    ff_row_q, ff_row_d;
    logic [DATA_W-1:0]    ff_dat_q, ff_dat_d;
`endif

    logic [DATA_W-1:0] pat_data;
    logic              in_wait, tmo_hit, last_row, mismatch;

    bist_pattern_gen #(
        .PATTERN (PATTERN),
        .ROW_W   (ROW_W)
    ) u_pattern (
        .row_i    (row_q),
        .data_c_o (pat_data)
    );

    assign in_wait  = (state_q == ST_WR_WAIT) || (state_q == ST_RD_WAIT);
    // An ack arriving on the expiry edge takes priority over the timeout.
    assign tmo_hit  = in_wait && !wbm_ack_i && (tcnt_q == TCNT_LAST);
    assign last_row = (row_q == LAST_ROW);
    assign mismatch = (state_q == ST_RD_WAIT) && wbm_ack_i && (wbm_dat_i != pat_data);

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start_i) state_d = ST_WR_REQ;
            ST_WR_REQ:  state_d = ST_WR_WAIT;
            ST_WR_WAIT: if (wbm_ack_i) state_d = ST_WR_GAP;
                        else if (tmo_hit) state_d = ST_DONE;
            ST_WR_GAP:  state_d = last_row ? ST_RD_REQ : ST_WR_REQ;
            ST_RD_REQ:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: if (wbm_ack_i) state_d = ST_RD_GAP;
                        else if (tmo_hit) state_d = ST_DONE;
            ST_RD_GAP:  state_d = last_row ? ST_DONE : ST_RD_REQ;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values; everything holds unless a state acts on it.
    always_comb begin
        cyc_d  = cyc_q;
        stb_d  = stb_q;
        we_d   = we_q;
        sel_d  = sel_q;
        adr_d  = adr_q;
        dat_d  = dat_q;
        row_d  = row_q;
        tcnt_d = tcnt_q;
        busy_d = busy_q;
        done_d = done_q;
        pass_d = pass_q;
        tmo_d  = tmo_q;
        err_d  = err_q;
`ifdef BIST_ERR_CAPTURE_EN
        ff_row_d = ff_row_q;
        ff_dat_d = ff_dat_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    pass_d = 1'b0;
                    tmo_d  = 1'b0;
                    err_d  = '0;
                    row_d  = '0;
`ifdef BIST_ERR_CAPTURE_EN
                    ff_row_d = '0;
                    ff_dat_d = '0;
`endif
                end
            end
            ST_WR_REQ, ST_RD_REQ: begin
                cyc_d  = 1'b1;
                stb_d  = 1'b1;
                we_d   = (state_q == ST_WR_REQ);
                sel_d  = SEL_ALL;
                adr_d  = BASE_ADDR + (DATA_W'(row_q) << 2);
                dat_d  = (state_q == ST_WR_REQ) ? pat_data : '0;
                tcnt_d = '0;
            end
            ST_WR_WAIT, ST_RD_WAIT: begin
                if (wbm_ack_i || tmo_hit) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    sel_d = '0;
                end
                if (wbm_ack_i) begin
                    if (mismatch) begin
                        if (err_q != {ERR_CNT_W{1'b1}}) err_d = err_q + ERR_CNT_W'(1);
`ifdef BIST_ERR_CAPTURE_EN
                        // err_q==0 marks the first mismatch of this run.
                        if (err_q == '0) begin
                            ff_row_d = row_q[ADDR_W-1:0];
                            ff_dat_d = wbm_dat_i;
                        end
`endif
                    end
                end else if (tmo_hit) begin
                    tmo_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            ST_WR_GAP: row_d = last_row ? '0 : row_q + ROW_W'(1);
            ST_RD_GAP: row_d = last_row ? row_q : row_q + ROW_W'(1);
            ST_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                pass_d = (err_q == '0) && !tmo_q;
            end
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cyc_q  <= 1'b0;
            stb_q  <= 1'b0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            adr_q  <= '0;
            dat_q  <= '0;
            row_q  <= '0;
            tcnt_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            tmo_q  <= 1'b0;
            err_q  <= '0;
`ifdef BIST_ERR_CAPTURE_EN
            ff_row_q <= '0;
            ff_dat_q <= '0;
`endif
        end else begin
            cyc_q  <= cyc_d;
            stb_q  <= stb_d;
            we_q   <= we_d;
            sel_q  <= sel_d;
            adr_q  <= adr_d;
            dat_q  <= dat_d;
            row_q  <= row_d;
            tcnt_q <= tcnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
            tmo_q  <= tmo_d;
            err_q  <= err_d;
`ifdef BIST_ERR_CAPTURE_EN
            ff_row_q <= ff_row_d;
            ff_dat_q <= ff_dat_d;
`endif
        end
    end

    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign timeout_o   = tmo_q;
    assign err_count_o = err_q;
`ifdef BIST_ERR_CAPTURE_EN
    assign first_fail_row_o  = ff_row_q;
    assign first_fail_data_o = ff_dat_q;
`endif

endmodule

// File: tb/tb_wishbone_bist_master.sv
// Bench for wishbone_bist_master: a 4-row instance against a RAM model with
// fault injection (corrupt read, withheld ack), plus a 1-row instance.
// Expected bus transfers go into per-instance queues; a negedge monitor pops
// and compares on every ack handshake and checks the idle cycle that follows.
`timescale 1ns/1ps
module tb_wishbone_bist_master;
    import bist_pkg::*;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;
    localparam logic [31:0] EXP_DAT [4] = '{32'hA5A5_A5A5, 32'hA5A5_A5A4,
                                             32'hA5A5_A5A7, 32'hA5A5_A5A6};

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } xfer_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start_b = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    xfer_t sbq[$];
    xfer_t sbq_b[$];

    // 4-row instance
    logic        cyc, stb, we, ack, busy, done, pass, tmo;
    logic [3:0]  sel;
    logic [31:0] adr, dato, dati;
    logic [15:0] err;
    // 1-row instance
    logic        cyc_b, stb_b, we_b, ack_b, busy_b, done_b, pass_b, tmo_b;
    logic [3:0]  sel_b;
    logic [31:0] adr_b, dato_b, dati_b;
    logic [15:0] err_b;
`ifdef BIST_ERR_CAPTURE_EN
    logic [1:0]  ff_row;
    logic [31:0] ff_dat;
    logic [0:0]  ff_row_b;
    logic [31:0] ff_dat_b;
`endif

    wishbone_bist_master #(.NO_OF_ROWS(4), .BASE_ADDR(BASE),
                           .PATTERN(32'hA5A5_A5A5), .TIMEOUT_CYCLES(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dato), .wbm_dat_i(dati), .wbm_ack_i(ack),
        .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(tmo),
        .err_count_o(err)
`ifdef BIST_ERR_CAPTURE_EN
        , .first_fail_row_o(ff_row), .first_fail_data_o(ff_dat)
`endif
    );

    wishbone_bist_master #(.NO_OF_ROWS(1), .BASE_ADDR(BASE),
                           .PATTERN(32'hA5A5_A5A5), .TIMEOUT_CYCLES(16)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_b),
        .wbm_cyc_o(cyc_b), .wbm_stb_o(stb_b), .wbm_we_o(we_b), .wbm_sel_o(sel_b),
        .wbm_adr_o(adr_b), .wbm_dat_o(dato_b), .wbm_dat_i(dati_b), .wbm_ack_i(ack_b),
        .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .timeout_o(tmo_b),
        .err_count_o(err_b)
`ifdef BIST_ERR_CAPTURE_EN
        , .first_fail_row_o(ff_row_b), .first_fail_data_o(ff_dat_b)
`endif
    );

    // RAM model: acks one cycle after it sees stb (second cycle of the strobe).
    logic [31:0] mem [4];
    logic [31:0] noack_adr = NONE;
    logic [31:0] bad_adr   = NONE;
    always @(posedge clk) begin
        if (rst) begin
            ack <= 1'b0;
        end else if (cyc && stb && !ack && adr != noack_adr) begin
            ack  <= 1'b1;
            dati <= mem[adr[3:2]] ^ ((adr == bad_adr) ? 32'h1 : 32'h0);
            if (we) mem[adr[3:2]] <= dato;
        end else begin
            ack <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst) ack_b <= 1'b0;
        else     ack_b <= cyc_b && stb_b && !ack_b;
        dati_b <= 32'hA5A5_A5A5;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic score(input string tag, input bit has, input xfer_t e, input logic w,
                         input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        n_cmp++;
        if (!has) begin
            n_bad++;
            $display("FAIL %s unexpected transfer: we=%b adr=%h dat=%h, none required", tag, w, a, d);
        end else if (w !== e.we || a !== e.adr || s !== SEL_ALL || (e.we && d !== e.dat)) begin
            n_bad++;
            $display("FAIL %s: got we=%b adr=%h sel=%h dat=%h required we=%b adr=%h sel=f dat=%h",
                     tag, w, a, s, d, e.we, e.adr, e.dat);
        end
    endtask

    // Monitor: score each handshake, then require cyc=stb=0 on the next cycle.
    initial begin : monitor
        bit    has;
        xfer_t e;
        bit    gap_a = 1'b0;
        bit    gap_b = 1'b0;
        forever begin
            @(negedge clk);
            if (gap_a) begin
                n_cmp++;
                if (cyc || stb) begin
                    n_bad++;
                    $display("FAIL gap_a: cyc=%b stb=%b required 0 0", cyc, stb);
                end
            end
            if (gap_b) begin
                n_cmp++;
                if (cyc_b || stb_b) begin
                    n_bad++;
                    $display("FAIL gap_b: cyc=%b stb=%b required 0 0", cyc_b, stb_b);
                end
            end
            gap_a = !rst && cyc && stb && ack;
            gap_b = !rst && cyc_b && stb_b && ack_b;
            if (gap_a) begin
                has = (sbq.size() != 0);
                e   = has ? sbq.pop_front() : '0;
                score("xfer_a", has, e, we, sel, adr, dato);
            end
            if (gap_b) begin
                has = (sbq_b.size() != 0);
                e   = has ? sbq_b.pop_front() : '0;
                score("xfer_b", has, e, we_b, sel_b, adr_b, dato_b);
            end
        end
    end

    task automatic push_all();
        for (int r = 0; r < 4; r++) sbq.push_back('{1'b1, BASE + 32'(r * 4), EXP_DAT[r]});
        for (int r = 0; r < 4; r++) sbq.push_back('{1'b0, BASE + 32'(r * 4), 32'h0});
    endtask

    // Pulse start, optionally re-pulse at cycle mid, and count cycles to done.
    task automatic run_a(input int mid, output int cyc_n);
        int n = 0;
        start = 1'b1;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (n == 1) begin
                check("start_busy", 32'(busy), 32'd1);
                check("start_done_clr", 32'(done), 32'd0);
                check("start_err_clr", 32'(err), 32'd0);
                check("start_tmo_clr", 32'(tmo), 32'd0);
            end
            if (n == mid) start = 1'b1;
        end while (!done && n < 200);
        cyc_n = n;
    endtask

    initial begin : main
        int n;
        int k;
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_cyc", 32'(cyc), 32'd0);
        check("rst_stb", 32'(stb), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_adr", adr, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_tmo", 32'(tmo), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_b_cyc", 32'(cyc_b), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // T1: clean run
        push_all();
        run_a(0, n);
        check("t1_cycles", 32'(n), 32'd34);
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_err", 32'(err), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_sb_empty", 32'(sbq.size()), 32'd0);

        // T2: row 2 read returns bit0 flipped
        bad_adr = BASE + 32'h8;
        push_all();
        run_a(0, n);
        bad_adr = NONE;
        check("t2_cycles", 32'(n), 32'd34);
        check("t2_err", 32'(err), 32'd1);
        check("t2_pass", 32'(pass), 32'd0);
`ifdef BIST_ERR_CAPTURE_EN
        check("t2_ff_row", 32'(ff_row), 32'd2);
        check("t2_ff_data", ff_dat, 32'hA5A5_A5A6);
`endif
        repeat (3) @(negedge clk);
        check("t2_done_sticky", 32'(done), 32'd1);

        // T5: start pulse mid-run is ignored; accepted start cleared err/done
        push_all();
        run_a(10, n);
        check("t5_cycles", 32'(n), 32'd34);
        check("t5_err", 32'(err), 32'd0);
        check("t5_pass", 32'(pass), 32'd1);
        repeat (3) @(negedge clk);
        check("t5_still_idle", 32'(busy), 32'd0);
`ifdef BIST_ERR_CAPTURE_EN
        check("t5_ff_row_clr", 32'(ff_row), 32'd0);
`endif

        // T3: row 1 write never acked
        noack_adr = BASE + 32'h4;
        sbq.push_back('{1'b1, BASE, EXP_DAT[0]});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(stb && adr == BASE + 32'h4) && k < 50) begin @(negedge clk); k++; end
        check("t3_reach_row1", 32'(k < 50), 32'd1);
        n = 0;
        while (stb && n < 40) begin @(negedge clk); n++; end
        check("t3_stb_cycles", 32'(n), 32'd16);
        check("t3_cyc_drop", 32'(cyc), 32'd0);
        k = 0;
        while (!done && k < 20) begin @(negedge clk); k++; end
        check("t3_done", 32'(done), 32'd1);
        check("t3_tmo", 32'(tmo), 32'd1);
        check("t3_pass", 32'(pass), 32'd0);
        check("t3_sb_empty", 32'(sbq.size()), 32'd0);
        noack_adr = NONE;

        // T4: reset during row-3 read wait; start on the reset edge is ignored
        bad_adr = BASE;
        push_all();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(stb && !we && adr == BASE + 32'hC) && k < 100) begin @(negedge clk); k++; end
        check("t4_reach_rd3", 32'(k < 100), 32'd1);
        check("t4_err_before", 32'(err), 32'd1);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_cyc", 32'(cyc), 32'd0);
        check("t4_stb", 32'(stb), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_done", 32'(done), 32'd0);
        check("t4_err", 32'(err), 32'd0);
        sbq.delete();
        bad_adr = NONE;
        rst = 1'b0;
        @(negedge clk);
        check("t4_start_ignored", 32'(busy), 32'd0);
        push_all();
        run_a(0, n);
        check("t4_rerun_cycles", 32'(n), 32'd34);
        check("t4_rerun_pass", 32'(pass), 32'd1);

        // T6: single-row instance
        sbq_b.push_back('{1'b1, BASE, 32'hA5A5_A5A5});
        sbq_b.push_back('{1'b0, BASE, 32'h0});
        start_b = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start_b = 1'b0;
            n++;
        end while (!done_b && n < 100);
        check("t6_cycles", 32'(n), 32'd10);
        check("t6_pass", 32'(pass_b), 32'd1);
        check("t6_err", 32'(err_b), 32'd0);
        check("t6_sb_empty", 32'(sbq_b.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
